// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: registered multiplier issue plus an iterative restoring divider.
// Optional divide result cache enabled by defining MULDIV_RESULT_CACHE_EN.
module muldiv_ctrl #(
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [2:0]        MDFunc,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic              flush,
  output logic [DWIDTH-1:0] mulA,
  output logic [DWIDTH-1:0] mulB,
  output logic [2:0]        mulFunc,
  output logic              mulEn,
  input  logic [DWIDTH-1:0] mulResult,
  output logic              busy,
  output logic              stall,
  output logic              valid,
  output logic [DWIDTH-1:0] MDOut
);

  localparam int CW = $clog2(DWIDTH + 1);
  localparam logic [DWIDTH-1:0] MIN = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_n;

  logic [CW-1:0]     cnt;
  logic [DWIDTH:0]   rem;
  logic [DWIDTH-1:0] quot;
  logic [DWIDTH-1:0] dvsr;
  logic              neg_q;
  logic              neg_r;

  logic              can_acc;
  logic              accept;
  logic              is_div;
  logic              sgn;
  logic              is_rem;
  logic              b_zero;
  logic              ovf;
  logic              hit;
  logic              fast;
  logic [DWIDTH-1:0] hit_res;
  logic [DWIDTH-1:0] fast_res;
  logic [DWIDTH-1:0] abs_a;
  logic [DWIDTH-1:0] abs_b;
  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   diff;
  logic [DWIDTH:0]   rem_n;
  logic [DWIDTH-1:0] quot_n;
  logic [DWIDTH-1:0] q_fix;
  logic [DWIDTH-1:0] r_fix;
  logic              last;

  assign can_acc = (state == IDLE) || (state == DONE);
  assign accept  = start && can_acc && !flush;
  assign is_div  = MDFunc[2];
  assign sgn     = !MDFunc[0];
  assign is_rem  = MDFunc[1];
  assign b_zero  = (B == '0);
  assign ovf     = sgn && (A == MIN) && (B == '1);
  assign abs_a   = (sgn && A[DWIDTH-1]) ? -A : A;
  assign abs_b   = (sgn && B[DWIDTH-1]) ? -B : B;

`ifdef MULDIV_RESULT_CACHE_EN
  logic [DWIDTH-1:0] c_a;
  logic [DWIDTH-1:0] c_b;
  logic              c_sgn;
  logic [DWIDTH-1:0] c_q;
  logic [DWIDTH-1:0] c_r;
  logic              c_valid;

  assign hit = c_valid && (A == c_a) && (B == c_b)
               && (MDFunc[0] == c_sgn);
  assign hit_res = is_rem ? c_r : c_q;
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  assign fast = is_div && (b_zero || ovf || hit);

  always_comb begin
    fast_res = hit_res;
    if (b_zero)
      fast_res = is_rem ? A : '1;
    else if (ovf)
      fast_res = is_rem ? '0 : A;
  end

  // One restoring step: shift in the next dividend bit, keep the
  // difference only when the trial subtract does not borrow.
  assign shifted = (rem << 1) | {{DWIDTH{1'b0}}, quot[DWIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign rem_n   = diff[DWIDTH] ? shifted : diff;
  assign quot_n  = {quot[DWIDTH-2:0], !diff[DWIDTH]};
  assign q_fix   = neg_q ? -quot_n : quot_n;
  assign r_fix   = neg_r ? -rem_n[DWIDTH-1:0] : rem_n[DWIDTH-1:0];
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clock) begin
    if (!nReset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    mulEn   = 1'b0;
    valid   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        valid   = (state == DONE);
        state_n = IDLE;
        if (accept)
          state_n = !is_div ? MUL : (fast ? DONE : DIV);
      end
      MUL: begin
        busy    = 1'b1;
        mulEn   = 1'b1;
        state_n = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (last)
          state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (flush)
      state_n = IDLE;
    stall = (start && can_acc && !fast) || busy;
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      mulA    <= '0;
      mulB    <= '0;
      mulFunc <= '0;
      MDOut   <= '0;
      rem     <= '0;
      quot    <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (accept) begin
      mulA    <= A;
      mulB    <= B;
      mulFunc <= MDFunc;
      if (fast) begin
        MDOut <= fast_res;
      end else if (is_div) begin
        rem   <= '0;
        quot  <= abs_a;
        dvsr  <= abs_b;
        cnt   <= CW'(DWIDTH);
        neg_q <= sgn && (A[DWIDTH-1] ^ B[DWIDTH-1]);
        neg_r <= sgn && A[DWIDTH-1];
      end
    end else if (!flush && state == MUL) begin
      MDOut <= mulResult;
    end else if (!flush && state == DIV) begin
      rem  <= rem_n;
      quot <= quot_n;
      cnt  <= cnt - CW'(1);
      if (last)
        MDOut <= mulFunc[1] ? r_fix : q_fix;
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  always_ff @(posedge clock) begin
    if (!nReset) begin
      c_a     <= '0;
      c_b     <= '0;
      c_sgn   <= 1'b0;
      c_q     <= '0;
      c_r     <= '0;
      c_valid <= 1'b0;
    end else if (state == DIV) begin
      if (flush) begin
        c_valid <= 1'b0;
      end else if (last) begin
        c_a     <= mulA;
        c_b     <= mulB;
        c_sgn   <= mulFunc[0];
        c_q     <= q_fix;
        c_r     <= r_fix;
        c_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural combinational multiplier.
// Expected latencies follow MULDIV_RESULT_CACHE_EN when the bench is built with it.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        nReset;
  logic        start;
  logic [2:0]  MDFunc;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic [31:0] mulA;
  logic [31:0] mulB;
  logic [2:0]  mulFunc;
  logic        mulEn;
  logic [31:0] mulResult;
  logic        busy;
  logic        stall;
  logic        valid;
  logic [31:0] MDOut;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  muldiv_ctrl #(.DWIDTH(32)) dut (
    .clock(clock), .nReset(nReset), .start(start), .MDFunc(MDFunc),
    .A(A), .B(B), .flush(flush), .mulA(mulA), .mulB(mulB),
    .mulFunc(mulFunc), .mulEn(mulEn), .mulResult(mulResult),
    .busy(busy), .stall(stall), .valid(valid), .MDOut(MDOut)
  );

  logic signed [63:0] sa, sb;
  logic [63:0] ua, ub, prod;
  always_comb begin
    sa = {{32{mulA[31]}}, mulA};
    sb = {{32{mulB[31]}}, mulB};
    ua = {32'h0, mulA};
    ub = {32'h0, mulB};
    prod = ua * ub;
    case (mulFunc[1:0])
      2'b01:   prod = sa * sb;
      2'b10:   prod = sa * $signed(ub);
      default: prod = ua * ub;
    endcase
    mulResult = (mulFunc[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one op and waits (bounded) for valid; edges = -1 on timeout.
  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, output int edges,
                       output int stalls);
    MDFunc = f; A = a; B = b; start = 1'b1;
    stalls = 0;
    #1;
    if (stall) stalls++;
    step();
    start = 1'b0;
    edges = 1;
    while (!valid && edges < 100) begin
      #1;
      if (stall) stalls++;
      step();
      edges++;
    end
    if (!valid) edges = -1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; start = 1'b0; flush = 1'b0;
    MDFunc = 3'b0; A = '0; B = '0;
    step(); step();
    tests++;
    if ({valid, busy, mulEn, stall} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags got %b exp 0000", {valid, busy, mulEn, stall});
    end
    tests++;
    if ({MDOut, mulA, mulB, mulFunc} !== '0) begin
      fails++;
      $display("FAIL reset_regs got %h/%h/%h/%h exp 0", MDOut, mulA, mulB, mulFunc);
    end
    nReset = 1'b1;
    step();
  endtask

  task automatic test_mul();
    int e, s;
    MDFunc = 3'b000; A = 32'd7; B = 32'hFFFFFFFD; start = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL mul_stall0 got %b exp 1", stall);
    end
    step();
    start = 1'b0;
    tests++;
    if ({mulEn, busy, stall, valid} !== 4'b1110) begin
      fails++; $display("FAIL mul_state got %b exp 1110", {mulEn, busy, stall, valid});
    end
    step();
    tests++;
    if ({mulEn, busy, stall, valid} !== 4'b0001) begin
      fails++; $display("FAIL mul_done got %b exp 0001", {mulEn, busy, stall, valid});
    end
    tests++;
    if (MDOut !== 32'hFFFFFFEB) begin
      fails++; $display("FAIL mul_result got %h exp ffffffeb", MDOut);
    end
    step();
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL mul_valid_pulse got %b exp 0", valid);
    end
    issue(3'b000, 32'd6, 32'd7, e, s);
    tests++;
    if (e !== 2 || s !== 2 || MDOut !== 32'd42) begin
      fails++; $display("FAIL mul_issue got e=%0d s=%0d %h exp 2 2 0000002a", e, s, MDOut);
    end
  endtask

  task automatic test_div_rem();
    int e, s, ee;
    issue(3'b100, 32'hFFFFFFEC, 32'd3, e, s);
    tests++;
    if (e !== 33 || s !== 33) begin
      fails++; $display("FAIL div_latency got e=%0d s=%0d exp 33 33", e, s);
    end
    tests++;
    if (MDOut !== 32'hFFFFFFFA) begin
      fails++; $display("FAIL div_result got %h exp fffffffa", MDOut);
    end
    issue(3'b110, 32'hFFFFFFEC, 32'd3, e, s);
`ifdef MULDIV_RESULT_CACHE_EN
    ee = 1;
`else
    ee = 33;
`endif
    tests++;
    if (e !== ee || s !== (ee == 1 ? 0 : 33)) begin
      fails++; $display("FAIL rem_latency got e=%0d s=%0d exp %0d", e, s, ee);
    end
    tests++;
    if (MDOut !== 32'hFFFFFFFE) begin
      fails++; $display("FAIL rem_result got %h exp fffffffe", MDOut);
    end
  endtask

  task automatic test_div_by_zero();
    int e, s;
    issue(3'b101, 32'd100, 32'd0, e, s);
    tests++;
    if (e !== 1 || s !== 0 || MDOut !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL divu_zero got e=%0d s=%0d %h exp 1 0 ffffffff", e, s, MDOut);
    end
    issue(3'b111, 32'd100, 32'd0, e, s);
    tests++;
    if (e !== 1 || s !== 0 || MDOut !== 32'd100) begin
      fails++; $display("FAIL remu_zero got e=%0d s=%0d %h exp 1 0 00000064", e, s, MDOut);
    end
  endtask

  task automatic test_overflow();
    int e, s;
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, e, s);
    tests++;
    if (e !== 1 || s !== 0 || MDOut !== 32'h80000000) begin
      fails++; $display("FAIL div_ovf got e=%0d s=%0d %h exp 1 0 80000000", e, s, MDOut);
    end
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, e, s);
    tests++;
    if (e !== 1 || s !== 0 || MDOut !== 32'h0) begin
      fails++; $display("FAIL rem_ovf got e=%0d s=%0d %h exp 1 0 0", e, s, MDOut);
    end
  endtask

  task automatic test_start_ignored();
    int e;
    MDFunc = 3'b101; A = 32'd100; B = 32'd7; start = 1'b1;
    step();
    MDFunc = 3'b100; A = 32'd5; B = 32'd1;
    step(); step(); step();
    start = 1'b0;
    e = 4;
    while (!valid && e < 100) begin
      step();
      e++;
    end
    tests++;
    if (e !== 33) begin
      fails++; $display("FAIL ignore_latency got %0d exp 33", e);
    end
    tests++;
    if (MDOut !== 32'd14 || mulA !== 32'd100 || mulB !== 32'd7) begin
      fails++; $display("FAIL ignore_result got %h a=%h b=%h exp 0000000e 64 7", MDOut, mulA, mulB);
    end
  endtask

  task automatic test_flush();
    int e, s, seen;
    MDFunc = 3'b101; A = 32'd1000; B = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 2; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++;
    if ({busy, valid, mulEn} !== 3'b000 || MDOut !== 32'd14) begin
      fails++; $display("FAIL flush_state got %b %h exp 000 0000000e", {busy, valid, mulEn}, MDOut);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid || busy) seen++;
      step();
    end
    tests++;
    if (seen !== 0 || MDOut !== 32'd14) begin
      fails++; $display("FAIL flush_quiet got %0d %h exp 0 0000000e", seen, MDOut);
    end
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, e, s);
    tests++;
    if (e !== 2 || MDOut !== 32'hFFFFFFFE) begin
      fails++; $display("FAIL mulhu got e=%0d %h exp 2 fffffffe", e, MDOut);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    MDFunc = 3'b100; A = 32'hFFFFFFEC; B = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    nReset = 1'b0;
    step();
    tests++;
    if ({valid, busy, mulEn, stall} !== 4'b0 || MDOut !== '0) begin
      fails++; $display("FAIL rst_mid_flags got %b %h exp 0000 0", {valid, busy, mulEn, stall}, MDOut);
    end
    tests++;
    if ({mulA, mulB, mulFunc} !== '0) begin
      fails++; $display("FAIL rst_mid_regs got %h %h %h exp 0", mulA, mulB, mulFunc);
    end
    nReset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL rst_mid_quiet got %0d exp 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int e, s;
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, e, s);
    tests++;
    if (e !== 2 || MDOut !== 32'h0) begin
      fails++; $display("FAIL mulh got e=%0d %h exp 2 0", e, MDOut);
    end
    issue(3'b100, 32'd7, 32'hFFFFFFFE, e, s);
    tests++;
    if (e !== 33 || MDOut !== 32'hFFFFFFFD) begin
      fails++; $display("FAIL div_b2b got e=%0d %h exp 33 fffffffd", e, MDOut);
    end
    issue(3'b010, 32'hFFFFFFFF, 32'd2, e, s);
    tests++;
    if (e !== 2 || MDOut !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL mulhsu got e=%0d %h exp 2 ffffffff", e, MDOut);
    end
    step();
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL b2b_valid_drop got %b exp 0", valid);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_rem();
    test_div_by_zero();
    test_overflow();
    test_start_ignored();
    test_flush();
    test_reset_mid_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the RV32M multiply/divide unit in the CPU execute stage. Accepts one M-extension operation at a time from the decoder. MUL/MULH/MULHSU/MULHU are issued to the combinational multiplier and the result is registered. DIV/DIVU/REM/REMU run on an internal iterative restoring divider, and the block stalls the pipeline until the result is valid.

Parameters:
DWIDTH, 32, operand/result width; division takes DWIDTH iterations.

Ports:
clock  input  1  system clock; all state changes on rising edge
nReset  input  1  synchronous, active-low reset
start  input  1  issue request; sampled only in IDLE or DONE
MDFunc  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
A  input  DWIDTH  rs1 operand
B  input  DWIDTH  rs2 operand
flush  input  1  kill in-flight operation (branch/trap)
mulA  output  DWIDTH  latched rs1 to multiplier
mulB  output  DWIDTH  latched rs2 to multiplier
mulFunc  output  3  latched funct3 to multiplier
mulEn  output  1  multiplier enable, high only in MUL state
mulResult  input  DWIDTH  combinational multiplier result
busy  output  1  high in MUL or DIV state
stall  output  1  pipeline hold: (start & state in {IDLE, DONE} & no fast path) | busy
valid  output  1  MDOut valid, high for exactly one cycle (DONE)
MDOut  output  DWIDTH  result register

Behaviour:
- Reset (nReset=0 at edge): state=IDLE; MDOut=0; valid=0; busy=0; mulEn=0; mulA/mulB/mulFunc=0; divider registers and counter cleared. Reset mid-operation aborts without producing valid.
- States: IDLE, MUL, DIV, DONE. DONE lasts one cycle and then goes to IDLE, unless a new start is accepted in DONE, which is legal for back-to-back issue.
- Accept, start=1 in IDLE/DONE at edge E: latch A, B, MDFunc.
  - MDFunc[2]=0: go to MUL.
  - B==0: fast path straight to DONE. DIV/DIVU result = all ones. REM/REMU result = A.
  - Signed overflow (DIV/REM, A=1<<(DWIDTH-1), B=all ones): fast path to DONE. DIV result = A. REM result = 0.
  - Otherwise: go to DIV with counter=DWIDTH. For signed ops, operands are converted to magnitudes and the quotient/remainder signs are recorded.
- MUL: one cycle with mulEn=1. At the next edge, mulResult is captured into MDOut and the state goes to DONE. Latency: start edge to valid cycle = 2 edges.
- DIV: one restoring step per edge: shift {rem,quot} left 1, trial-subtract divisor, set quot LSB if no borrow, decrement counter. On the edge where counter goes 1->0, write the sign-corrected quotient or remainder to MDOut and go to DONE.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
  - Latency: DWIDTH+1 edges (33 for DWIDTH=32).
- Fast-path latency: 1 edge. stall stays low for fast-path ops.
- start while busy: ignored; no re-latch.
- flush=1 at an edge: state goes to IDLE, valid=0 next cycle, and MDOut holds its old value. flush has priority over start and over completion on the same edge.
- MDOut holds its value until the next completion. valid falls after one cycle regardless of start.
- All arithmetic is modulo 2^DWIDTH. The remainder register is DWIDTH+1 bits for the borrow.

Optional Feature:
MULDIV_RESULT_CACHE_EN
- Defined: on each normal division completion, store A, B, signedness (MDFunc[0]), quotient and remainder, and set cacheValid. A later DIV/REM start with identical A, B and signedness while cacheValid is set completes in 1 edge from the cache (DIV after REM returns the stored quotient, and vice versa), with no stall.
  - cacheValid is cleared by reset and by flush during DIV.
  - Fast-path ops do not update the cache.
- Undefined: no cache storage; every non-special division takes DWIDTH+1 edges.

Test Plan:
- Reset then MUL, A=7, B=-3 (0xFFFFFFFD) -> mulEn high one cycle; valid 2 edges after start; MDOut=0xFFFFFFEB; stall high for exactly 2 cycles.
- DIV A=-20 (0xFFFFFFEC), B=3 -> valid on edge 33, MDOut=0xFFFFFFFA (-6); REM with the same operands -> 0xFFFFFFFE (-2), taking 33 edges without the cache and 1 edge with the cache.
- DIVU A=100, B=0 -> MDOut=0xFFFFFFFF after 1 edge, stall never high; REMU with the same operands -> MDOut=100.
- DIV A=0x80000000, B=0xFFFFFFFF -> MDOut=0x80000000 after 1 edge; REM -> 0.
- DIVU A=1000, B=7, flush asserted on edge 10 -> no valid pulse, state IDLE, MDOut unchanged. Next MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
- nReset low on edge 5 of a DIV -> all outputs return to reset values; start asserted during DIV is ignored (no relatch; result matches the original operands).
